// File: rtl/ysyx_23060240_trap_ctrl.sv
// Machine-mode trap/mret sequencer: arbitrates ecall, mret and timer irq,
// walks the mepc/mcause/mstatus/mtvec CSR updates and redirects fetch.
module ysyx_23060240_trap_ctrl #(
  parameter logic [31:0] ECALL_CAUSE = 32'h0000_000B,
  parameter logic [31:0] IRQ_CAUSE   = 32'h8000_0007
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_valid,
  input  logic        mret_valid,
  input  logic        irq_pending,
  input  logic        mstatus_mie,
  input  logic [31:0] cur_pc,
  output logic        ack,
  output logic [1:0]  ack_src,
  output logic        busy,
  output logic [11:0] csr_addr,
  output logic        csr_wen,
  output logic        csr_ren,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [3:0] {
    IDLE, T_EPC, T_CAUSE, T_SRD, T_SWR, T_VEC,
    R_SRD, R_SWR, R_EPC
  } state_t;

  localparam logic [1:0] SRC_ECALL = 2'b01;
  localparam logic [1:0] SRC_MRET  = 2'b10;
  localparam logic [1:0] SRC_IRQ   = 2'b11;

  state_t      state, state_nxt;
  logic [31:0] saved_pc, cause, status_q;
  logic [1:0]  sel;
  logic        accept;
  logic [31:0] trap_status, ret_status;
  logic [31:0] vec_base, vec_off;

  always_comb begin
    sel = 2'b00;
    if (irq_pending && mstatus_mie) sel = SRC_IRQ;
    else if (ecall_valid)           sel = SRC_ECALL;
    else if (mret_valid)            sel = SRC_MRET;
  end

  assign accept = !rst && (state == IDLE) && (sel != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)
              state_nxt = (sel == SRC_MRET) ? R_SRD : T_EPC;
      T_EPC:   state_nxt = T_CAUSE;
      T_CAUSE: state_nxt = T_SRD;
      T_SRD:   state_nxt = T_SWR;
      T_SWR:   state_nxt = T_VEC;
      T_VEC:   state_nxt = IDLE;
      R_SRD:   state_nxt = R_SWR;
      R_SWR:   state_nxt = R_EPC;
      R_EPC:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saved_pc <= '0;
      cause    <= '0;
      status_q <= '0;
    end else begin
      if (accept) begin
        saved_pc <= cur_pc;
        if (sel == SRC_IRQ)        cause <= IRQ_CAUSE;
        else if (sel == SRC_ECALL) cause <= ECALL_CAUSE;
      end
      if (state == T_SRD || state == R_SRD) status_q <= csr_rdata;
    end
  end

  // Trap stacks MIE into MPIE; mret restores it and re-arms MPIE.
  always_comb begin
    trap_status        = status_q;
    trap_status[7]     = status_q[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = 2'b11;
    ret_status         = status_q;
    ret_status[3]      = status_q[7];
    ret_status[7]      = 1'b1;
    ret_status[12:11]  = 2'b11;
  end

  assign vec_base = {csr_rdata[31:2], 2'b00};
  assign vec_off  = {1'b0, cause[30:0]} << 2;

  always_comb begin
    ack            = 1'b0;
    ack_src        = 2'b00;
    busy           = 1'b0;
    csr_addr       = 12'h000;
    csr_wen        = 1'b0;
    csr_ren        = 1'b0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          ack     = accept;
          ack_src = accept ? sel : 2'b00;
        end
        T_EPC: begin
          csr_wen   = 1'b1;
          csr_addr  = 12'h341;
          csr_wdata = saved_pc;
        end
        T_CAUSE: begin
          csr_wen   = 1'b1;
          csr_addr  = 12'h342;
          csr_wdata = cause;
        end
        T_SRD, R_SRD: begin
          csr_ren  = 1'b1;
          csr_addr = 12'h300;
        end
        T_SWR: begin
          csr_wen   = 1'b1;
          csr_addr  = 12'h300;
          csr_wdata = trap_status;
        end
        T_VEC: begin
          csr_ren        = 1'b1;
          csr_addr       = 12'h305;
          redirect_valid = 1'b1;
          if (csr_rdata[1:0] == 2'b01 && cause[31])
            redirect_pc = vec_base + vec_off;
          else
            redirect_pc = vec_base;
        end
        R_SWR: begin
          csr_wen   = 1'b1;
          csr_addr  = 12'h300;
          csr_wdata = ret_status;
        end
        R_EPC: begin
          csr_ren        = 1'b1;
          csr_addr       = 12'h341;
          redirect_valid = 1'b1;
          redirect_pc    = vec_base;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060240_trap_ctrl.md
YSYX_23060240_TRAP_CTRL -- requirements
Module: ysyx_23060240_trap_ctrl

Interface
REQ-001 SHALL have parameter ECALL_CAUSE, default 32'h0000_000B, mcause value written for ecall.
REQ-002 SHALL have parameter IRQ_CAUSE, default 32'h8000_0007, mcause value written for machine timer interrupt.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ecall_valid  input  1  ecall committing; held until ack.
REQ-006 SHALL have port mret_valid  input  1  mret committing; held until ack.
REQ-007 SHALL have port irq_pending  input  1  level interrupt request.
REQ-008 SHALL have port mstatus_mie  input  1  live mstatus[3] from CSR file.
REQ-009 SHALL have port cur_pc  input  32  pc of the committing/interrupted instruction.
REQ-010 SHALL have port ack  output  1  one-cycle accept pulse.
REQ-011 SHALL have port ack_src  output  2  accepted source: 01 ecall, 10 mret, 11 irq, 00 none.
REQ-012 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-013 SHALL have port csr_addr  output  12  CSR address driven to CSR file.
REQ-014 SHALL have port csr_wen  output  1  CSR write strobe.
REQ-015 SHALL have port csr_ren  output  1  CSR read enable.
REQ-016 SHALL have port csr_wdata  output  32  CSR write data.
REQ-017 SHALL have port csr_rdata  input  32  CSR read data, combinational, same cycle as csr_ren/csr_addr.
REQ-018 SHALL have port redirect_valid  output  1  one-cycle fetch redirect pulse.
REQ-019 SHALL have port redirect_pc  output  32  redirect target, valid with redirect_valid.

Function
REQ-020 SHALL implement FSM states IDLE, T_EPC, T_CAUSE, T_SRD, T_SWR, T_VEC, R_SRD, R_SWR, R_EPC.
REQ-021 In IDLE, acceptance priority SHALL be irq (irq_pending && mstatus_mie) > ecall_valid > mret_valid; one source per accept.
REQ-022 On accept (IDLE cycle): ack=1, ack_src set, cur_pc latched to saved_pc, cause latched (IRQ_CAUSE or ECALL_CAUSE); irq/ecall -> T_EPC, mret -> R_SRD.
REQ-023 Unaccepted requests SHALL receive no ack and be re-arbitrated on next IDLE cycle.
REQ-024 T_EPC: csr_wen=1, csr_addr=12'h341, csr_wdata=saved_pc; -> T_CAUSE.
REQ-025 T_CAUSE: csr_wen=1, addr 12'h342, wdata=cause; -> T_SRD.
REQ-026 T_SRD: csr_ren=1, addr 12'h300, csr_rdata latched to status_q; -> T_SWR.
REQ-027 T_SWR: csr_wen=1, addr 12'h300, wdata=status_q with bit7(MPIE)=status_q[3], bit3(MIE)=0, bits12:11(MPP)=2'b11, other bits unchanged; -> T_VEC.
REQ-028 T_VEC: csr_ren=1, addr 12'h305, redirect_valid=1; redirect_pc={rdata[31:2],2'b00} if rdata[1:0]!=2'b01 or cause[31]=0, else {rdata[31:2],2'b00}+(cause[30:0]<<2) mod 2^32; -> IDLE.
REQ-029 R_SRD: read 12'h300 into status_q; -> R_SWR.
REQ-030 R_SWR: write 12'h300, wdata=status_q with bit3=status_q[7], bit7=1, bits12:11=2'b11; -> R_EPC.
REQ-031 R_EPC: csr_ren=1, addr 12'h341, redirect_valid=1, redirect_pc={rdata[31:2],2'b00}; -> IDLE.
REQ-032 Latency SHALL be: trap redirect exactly 5 cycles after ack cycle; mret redirect exactly 3 cycles after ack.
REQ-033 csr_wen and csr_ren SHALL never be high simultaneously; both 0 and csr_addr/csr_wdata 0 in IDLE.
REQ-034 redirect_valid and ack SHALL never assert in same cycle; ack never asserts while busy=1.
REQ-035 irq_pending dropping or mstatus_mie changing after accept SHALL not alter an in-flight sequence.
REQ-036 No request accepted in the cycle the FSM returns to IDLE from T_VEC/R_EPC; acceptance resumes next cycle.

Reset
REQ-037 On rst=1 (any cycle, mid-sequence included) FSM SHALL enter IDLE immediately; all outputs 0, saved_pc, cause, status_q cleared to 0; no partial CSR write completes after reset asserts.
REQ-038 First accept SHALL be possible on the first posedge after rst deasserts.

Verification
REQ-039 ecall_valid=1, cur_pc=0x8000_0010, mtvec=0x8000_1000, mstatus=0x0000_0008 -> ack src 01; writes mepc=0x8000_0010, mcause=0xB, mstatus=0x0000_1880; redirect_pc=0x8000_1000 at ack+5.
REQ-040 mret_valid=1, mstatus=0x0000_1880, mepc=0x8000_0014 -> mstatus written 0x0000_1888; redirect_pc=0x8000_0014 at ack+3.
REQ-041 irq_pending=1, mstatus_mie=1, ecall_valid=1 same cycle, mtvec=0x8000_1001 -> ack src 11, mcause=0x8000_0007, redirect_pc=0x8000_101C; ecall acked 1 cycle after redirect.
REQ-042 irq_pending=1, mstatus_mie=0, no other request -> no ack, busy=0, no CSR traffic for 10 cycles.
REQ-043 rst asserted in T_SRD of an ecall sequence -> same-cycle outputs 0, IDLE, no mstatus write, no redirect.
